// File: rtl/regfile.sv
// Two-read, one-write architectural register file; x0 is hardwired to zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_ok;

    // x0 is never written, so its storage stays at the reset value of zero.
    assign wr_ok = we && (rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[rd] <= wd;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so reads stay zero while rst_n is low.
    always_comb begin
        rd1 = '0;
        if (rs1 != '0) begin
            if (rst_n && wr_ok && (rs1 == rd)) rd1 = wd;
            else                               rd1 = regs[rs1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (rs2 != '0) begin
            if (rst_n && wr_ok && (rs2 == rd)) rd2 = wd;
            else                               rd2 = regs[rs2];
        end
    end
`else
    always_comb begin
        rd1 = '0;
        if (rs1 != '0) rd1 = regs[rs1];
    end

    always_comb begin
        rd2 = '0;
        if (rs2 != '0) rd2 = regs[rs2];
    end
`endif

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus pushes expected read data into queues,
// a negedge monitor pops and compares whenever a check is presented.
module tb_regfile;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            rst_n;
    logic            we;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    logic            chk_vld;
    logic [XLEN-1:0] exp1_q[$];
    logic [XLEN-1:0] exp2_q[$];
    string           name_q[$];

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile #(.XLEN(XLEN), .NREGS(32), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .rs1   (rs1),
        .rs2   (rs2),
        .rd    (rd),
        .wd    (wd),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: reads are combinational, so sample mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_vld) begin
            checks++;
            if (exp1_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: check presented with empty queue");
            end else begin
                logic [XLEN-1:0] e1;
                logic [XLEN-1:0] e2;
                string           nm;
                e1 = exp1_q.pop_front();
                e2 = exp2_q.pop_front();
                nm = name_q.pop_front();
                if (rd1 !== e1) begin
                    errors++;
                    $display("FAIL %s.rd1: got %08h expected %08h", nm, rd1, e1);
                end
                checks++;
                if (rd2 !== e2) begin
                    errors++;
                    $display("FAIL %s.rd2: got %08h expected %08h", nm, rd2, e2);
                end
            end
        end
    end

    // One clock cycle of stimulus, applied 1 time unit after the rising edge.
    task automatic cycle(input logic r, input logic w, input logic [AW-1:0] d,
                         input logic [XLEN-1:0] dat, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input bit chk,
                         input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                         input string nm);
        @(posedge clk);
        #1;
        rst_n = r;
        we    = w;
        rd    = d;
        wd    = dat;
        rs1   = a1;
        rs2   = a2;
        if (chk) begin
            exp1_q.push_back(e1);
            exp2_q.push_back(e2);
            name_q.push_back(nm);
        end
        chk_vld = chk;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; rd = '0; wd = '0; rs1 = '0; rs2 = '0; chk_vld = 1'b0;

        // Reset held for two cycles, then released.
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_a");
        cycle(0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0, "in_reset_x1");
        cycle(1, 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, "reset_x0_x1");
        cycle(1, 0, 0, 0, 10, 31, 1, 32'h0, 32'h0, "reset_x10_x31");

        // Basic writes and reads.
        cycle(1, 1, 1, 32'h11111111, 0, 0, 0, 0, 0, "wr_x1");
        cycle(1, 0, 0, 0, 1, 0, 1, 32'h11111111, 32'h0, "rd_x1_x0");
        cycle(1, 1, 2, 32'h22222222, 0, 0, 0, 0, 0, "wr_x2");
        cycle(1, 1, 3, 32'h33333333, 0, 0, 0, 0, 0, "wr_x3");
        cycle(1, 0, 0, 0, 2, 3, 1, 32'h22222222, 32'h33333333, "rd_x2_x3");

        // we=0 must not write.
        cycle(1, 0, 4, 32'h44444444, 0, 0, 0, 0, 0, "nowr_x4");
        cycle(1, 0, 0, 0, 4, 4, 1, 32'h0, 32'h0, "rd_x4");

        // Write to x0 is discarded.
        cycle(1, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, "wr_x0");
        cycle(1, 0, 0, 0, 0, 1, 1, 32'h0, 32'h11111111, "rd_x0_x1");
        cycle(1, 0, 0, 0, 3, 3, 1, 32'h33333333, 32'h33333333, "same_idx");

        // Same-cycle read/write of x2: pre-edge value unless forwarding is built in.
        cycle(1, 1, 2, 32'h12345678, 2, 1, 1, BYP ? 32'h12345678 : 32'h22222222,
              32'h11111111, "rw_same_x2");
        cycle(1, 0, 0, 0, 2, 1, 1, 32'h12345678, 32'h11111111, "rd_x2_after");

        // Asynchronous reset mid-cycle; writes blocked while low.
        cycle(0, 1, 6, 32'h66666666, 1, 2, 1, 32'h0, 32'h0, "async_rst");
        cycle(0, 1, 6, 32'h66666666, 3, 0, 1, 32'h0, 32'h0, "rst_x3_x0");
        cycle(1, 0, 0, 0, 6, 3, 1, 32'h0, 32'h0, "post_rst_x6_x3");
        cycle(1, 0, 0, 0, 1, 2, 1, 32'h0, 32'h0, "post_rst_x1_x2");
        cycle(1, 1, 7, 32'h77777777, 0, 0, 0, 0, 0, "wr_x7");
        cycle(1, 0, 0, 0, 7, 6, 1, 32'h77777777, 32'h0, "rd_x7_x6");

        // Write-through of x5, and a write to x0 never forwarded.
        cycle(1, 1, 5, 32'hA5A5A5A5, 5, 0, 1, BYP ? 32'hA5A5A5A5 : 32'h0, 32'h0, "byp_x5");
        cycle(1, 0, 0, 0, 5, 5, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, "rd_x5");
        cycle(1, 1, 0, 32'hFFFFFFFF, 0, 0, 1, 32'h0, 32'h0, "byp_x0");
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
        @(posedge clk);
        @(posedge clk);

        checks++;
        if (exp1_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left expected 0", exp1_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: simulation ran past time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter XLEN, default 32: data width of every register and data port.
REQ-003 Parameter NREGS, default 32: number of architectural registers.
REQ-004 Parameter AW = log2(NREGS), default 5: width of every register index port.
REQ-005 clk  input  1  rising-edge clock for all writes.
REQ-006 rst_n  input  1  asynchronous active-low reset; clears the register array.
REQ-007 we  input  1  write enable, sampled on the clk rising edge.
REQ-008 rs1  input  AW  read port 1 register index.
REQ-009 rs2  input  AW  read port 2 register index.
REQ-010 rd  input  AW  write register index.
REQ-011 wd  input  XLEN  write data.
REQ-012 rd1  output  XLEN  read port 1 data (combinational).
REQ-013 rd2  output  XLEN  read port 2 data (combinational).

Function
REQ-014 The block SHALL hold NREGS registers of XLEN bits each, x0..x(NREGS-1).
REQ-015 Write: on each clk rising edge with rst_n=1, we=1 and rd!=0, x[rd] SHALL take wd; all other registers hold.
REQ-016 A clk edge with we=0 SHALL leave every register unchanged, regardless of rd and wd.
REQ-017 A write with rd=0 SHALL be discarded; x0 SHALL never store a nonzero value.
REQ-018 Read: rd1 = x[rs1] and rd2 = x[rs2], purely combinational, with zero-cycle latency after an rs1/rs2 change.
REQ-019 rs1=0 or rs2=0 SHALL yield 0 on the corresponding port, in every state.
REQ-020 Both read ports SHALL be independent; rs1=rs2 SHALL return the same value on both ports.
REQ-021 A written value SHALL be visible on the read ports immediately after the write edge and SHALL persist until the next write to that index or a reset.
REQ-022 Reading and writing the same index in one cycle SHALL return the pre-edge value, unless REGFILE_BYPASS_EN is defined (REQ-027).
REQ-023 rd1 and rd2 SHALL contain no X/Z after reset for any in-range index.

Reset
REQ-024 rst_n=0 SHALL clear all registers to 0 immediately, without waiting for a clock edge, so rd1=rd2=0 for every index while reset is asserted.
REQ-025 Writes SHALL be blocked while rst_n=0; a reset asserted mid-operation SHALL clear all previously written values.
REQ-026 After rst_n deasserts, the first clk edge with we=1 SHALL write normally.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN defined: when we=1, rd!=0 and rsN==rd, rdN SHALL equal wd combinationally (write-through forwarding); x0 SHALL still read 0.
REQ-028 Macro REGFILE_BYPASS_EN undefined: no forwarding; reads return stored contents only (REQ-022).

Verification
REQ-029 Hold rst_n=0 for 2 cycles, then release; read (x0,x1) and (x10,x31) -> all 00000000.
REQ-030 Write x1=11111111 with we=1, then read rs1=1, rs2=0 -> rd1=11111111, rd2=00000000; write x2=22222222 and x3=33333333, then read (2,3) -> 22222222, 33333333.
REQ-031 Set we=0, rd=4, wd=44444444, run one edge, then read x4 -> 00000000.
REQ-032 Set we=1, rd=0, wd=DEADBEEF, run one edge, then read (x0,x1) -> 00000000, 11111111.
REQ-033 Assert rst_n=0 asynchronously between edges -> rd1/rd2 go to 0 before the next edge; after release, read (x1,x2) and (x3,x0) -> all 0.
REQ-034 With we=1, rd=5, wd=A5A5A5A5, rs1=5 before the edge -> rd1=A5A5A5A5 if REGFILE_BYPASS_EN is defined, else 00000000; in both builds rd1=A5A5A5A5 after the edge.
